// File: rtl/cfar_pkg.sv
// Shared types and constants for the CFAR frame peak finder.
package cfar_pkg;

  localparam int CFAR_PWR_W = 29;

  typedef enum logic {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } state_t;

  // Index width that never collapses to zero bits for tiny frames.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/cfar_peak_cmp.sv
// Combinational compare/select: decides whether a new sample replaces the running peak.
module cfar_peak_cmp
  import cfar_pkg::*;
#(
  parameter int DATA_W   = CFAR_PWR_W,
  parameter int IDX_W    = 9,
  parameter bit TIE_LAST = 1'b0
) (
  input  logic [DATA_W-1:0] sample,
  input  logic [IDX_W-1:0]  idx,
  input  logic [DATA_W-1:0] run_max,
  input  logic [IDX_W-1:0]  run_idx,
  output logic [DATA_W-1:0] next_max,
  output logic [IDX_W-1:0]  next_idx
);

  logic take;

  always_comb begin
    // Equal values only displace the held peak when the latest index should win.
    take     = (sample > run_max) || (TIE_LAST && (sample == run_max));
    next_max = take ? sample : run_max;
    next_idx = take ? idx : run_idx;
  end

endmodule

// File: rtl/cfar_frame_peak_finder.sv
// Streaming per-frame peak search over CFAR power samples.
// Optional per-frame threshold hit counter enabled by defining CFAR_PEAK_THRESH_EN.
module cfar_frame_peak_finder
  import cfar_pkg::*;
#(
  parameter int  DATA_W    = CFAR_PWR_W,
  parameter int  FRAME_LEN = 512,
  parameter bit  TIE_LAST  = 1'b0,
  localparam int IDX_W     = clog2_min1(FRAME_LEN)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enb,
  input  logic [DATA_W-1:0] power_in,
  input  logic              input_valid,
  input  logic              frame_start,
`ifdef CFAR_PEAK_THRESH_EN
  input  logic [DATA_W-1:0] threshold,
  output logic [IDX_W:0]    hit_count,
`endif
  output logic [DATA_W-1:0] max_value,
  output logic [IDX_W-1:0]  index_out,
  output logic              max_valid,
  output logic              frame_err
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);

  state_t              state_reg;
  logic [IDX_W-1:0]    count_reg;
  logic [DATA_W-1:0]   run_max_reg;
  logic [IDX_W-1:0]    run_idx_reg;
  logic [DATA_W-1:0]   max_value_reg;
  logic [IDX_W-1:0]    index_out_reg;
  logic                max_valid_reg;
  logic                frame_err_reg;
  logic [DATA_W-1:0]   cmp_max;
  logic [IDX_W-1:0]    cmp_idx;
  logic                accept_start;
  logic                accept_cont;
  logic                accept_last;

  cfar_peak_cmp #(
    .DATA_W   (DATA_W),
    .IDX_W    (IDX_W),
    .TIE_LAST (TIE_LAST)
  ) u_cmp (
    .sample   (power_in),
    .idx      (count_reg),
    .run_max  (run_max_reg),
    .run_idx  (run_idx_reg),
    .next_max (cmp_max),
    .next_idx (cmp_idx)
  );

  // frame_start always (re)opens a frame; otherwise only ACCUM consumes samples.
  assign accept_start = enb && input_valid && frame_start;
  assign accept_cont  = enb && input_valid && !frame_start && (state_reg == ACCUM);
  assign accept_last  = accept_cont && (count_reg == LAST_IDX);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= IDLE;
      count_reg     <= '0;
      run_max_reg   <= '0;
      run_idx_reg   <= '0;
      max_value_reg <= '0;
      index_out_reg <= '0;
      max_valid_reg <= 1'b0;
      frame_err_reg <= 1'b0;
    end else if (enb) begin
      max_valid_reg <= 1'b0;
      frame_err_reg <= 1'b0;
      if (accept_start) begin
        frame_err_reg <= (state_reg == ACCUM);
        state_reg     <= ACCUM;
        run_max_reg   <= power_in;
        run_idx_reg   <= '0;
        count_reg     <= IDX_W'(1);
      end else if (accept_cont) begin
        run_max_reg <= cmp_max;
        run_idx_reg <= cmp_idx;
        if (accept_last) begin
          max_value_reg <= cmp_max;
          index_out_reg <= cmp_idx;
          max_valid_reg <= 1'b1;
          state_reg     <= IDLE;
          count_reg     <= '0;
        end else begin
          count_reg <= count_reg + IDX_W'(1);
        end
      end
    end
  end

`ifdef CFAR_PEAK_THRESH_EN
  logic [IDX_W:0] hit_acc_reg;
  logic [IDX_W:0] hit_count_reg;
  logic [IDX_W:0] hit_inc;

  assign hit_inc = {{IDX_W{1'b0}}, (power_in > threshold)};

  always_ff @(posedge clk) begin
    if (reset) begin
      hit_acc_reg   <= '0;
      hit_count_reg <= '0;
    end else if (accept_start) begin
      hit_acc_reg <= hit_inc;
    end else if (accept_last) begin
      hit_count_reg <= hit_acc_reg + hit_inc;
      hit_acc_reg   <= '0;
    end else if (accept_cont) begin
      hit_acc_reg <= hit_acc_reg + hit_inc;
    end
  end

  assign hit_count = hit_count_reg;
`endif

  assign max_value = max_value_reg;
  assign index_out = index_out_reg;
  assign max_valid = max_valid_reg;
  assign frame_err = frame_err_reg;

endmodule

// File: tb/tb_cfar_frame_peak_finder.sv
// Scoreboard bench for cfar_frame_peak_finder: two instances (earliest/latest tie policy) share stimulus.
// Hit-count checks are included when CFAR_PEAK_THRESH_EN is defined.
module tb_cfar_frame_peak_finder;
  import cfar_pkg::*;

  localparam int DW = 29;
  localparam int FL = 512;
  localparam int IW = 9;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          enb = 1'b1;
  logic          input_valid = 1'b0;
  logic          frame_start = 1'b0;
  logic [DW-1:0] power_in = '0;
  logic [DW-1:0] threshold = DW'(1000);

  logic [DW-1:0] max_value0, max_value1;
  logic [IW-1:0] index0, index1;
  logic          max_valid0, max_valid1, frame_err0, frame_err1;
`ifdef CFAR_PEAK_THRESH_EN
  logic [IW:0]   hit0, hit1;
`endif

  cfar_frame_peak_finder #(.DATA_W(DW), .FRAME_LEN(FL), .TIE_LAST(1'b0)) dut0 (
    .clk(clk), .reset(reset), .enb(enb), .power_in(power_in),
    .input_valid(input_valid), .frame_start(frame_start),
`ifdef CFAR_PEAK_THRESH_EN
    .threshold(threshold), .hit_count(hit0),
`endif
    .max_value(max_value0), .index_out(index0), .max_valid(max_valid0), .frame_err(frame_err0)
  );

  cfar_frame_peak_finder #(.DATA_W(DW), .FRAME_LEN(FL), .TIE_LAST(1'b1)) dut1 (
    .clk(clk), .reset(reset), .enb(enb), .power_in(power_in),
    .input_valid(input_valid), .frame_start(frame_start),
`ifdef CFAR_PEAK_THRESH_EN
    .threshold(threshold), .hit_count(hit1),
`endif
    .max_value(max_value1), .index_out(index1), .max_valid(max_valid1), .frame_err(frame_err1)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit is_err;
    int mx;
    int i0;
    int i1;
    int hits;
    int cyc;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_tests = 0;
  int   n_fail = 0;
  int   cyc = 0;
  bit   enb_s = 1'b1;
  int   frame_buf[FL];
  int   freeze_at = -1;
  int   pushed = 0;
  int   seen = 0;

  task automatic check(input string tag, input longint obs, input longint exp);
    n_tests++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic exp_t ref_frame();
    exp_t e;
    e.is_err = 1'b0;
    e.mx = frame_buf[0];
    e.i0 = 0;
    e.i1 = 0;
    e.hits = 0;
    e.cyc = 0;
    for (int i = 0; i < FL; i++) begin
      if (frame_buf[i] > e.mx) begin
        e.mx = frame_buf[i];
        e.i0 = i;
        e.i1 = i;
      end else if (frame_buf[i] == e.mx) begin
        e.i1 = i;
      end
      if (frame_buf[i] > int'(threshold)) e.hits++;
    end
    return e;
  endfunction

  task automatic fill_random();
    for (int i = 0; i < FL; i++) frame_buf[i] = int'($urandom & 32'h1FFF_FFFF);
  endtask

  task automatic drive(input int v, input bit fs, input bit vld);
    @(posedge clk);
    #1;
    power_in    = DW'(v);
    frame_start = fs;
    input_valid = vld;
  endtask

  task automatic drive_frame(input int n, input bit gaps, input bit aborts);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      drive(frame_buf[i], i == 0, 1'b1);
      if (i == 0 && aborts) begin
        e = '{1'b1, 0, 0, 0, 0, cyc + 1};
        sb.push_back(e);
        pushed++;
      end
      if (i == FL - 1) begin
        e = ref_frame();
        e.cyc = cyc + 1;
        sb.push_back(e);
        pushed++;
      end
      if (i == freeze_at) begin
        @(posedge clk);
        #1;
        enb = 1'b0;
        power_in = '1;
        frame_start = 1'b1;
        input_valid = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        enb = 1'b1;
        input_valid = 1'b0;
        frame_start = 1'b0;
      end
      if (gaps) drive(int'($urandom), 1'b1, 1'b0);
    end
  endtask

  always @(posedge clk) begin
    cyc   <= cyc + 1;
    enb_s <= enb;
  end

  // Only the first cycle of a pulse is a transaction; a frozen pulse is held, not repeated.
  always @(negedge clk) begin
    if (!reset && enb_s && (max_valid0 || frame_err0)) begin
      if (sb.size() == 0) begin
        check("unexpected_pulse", 1, 0);
      end else begin
        mon_e = sb.pop_front();
        seen++;
        check("pulse_kind_err", frame_err0, mon_e.is_err);
        check("pulse_kind_valid", max_valid0, !mon_e.is_err);
        if (mon_e.cyc >= 0) check("latency_cycle", cyc, mon_e.cyc);
        if (mon_e.is_err) begin
          check("tie1_frame_err", frame_err1, 1);
          $display("[TB] cycle %0d frame_err", cyc);
        end else begin
          check("max_value", max_value0, mon_e.mx);
          check("index_tie_first", index0, mon_e.i0);
          check("tie1_max_valid", max_valid1, 1);
          check("tie1_max_value", max_value1, mon_e.mx);
          check("index_tie_last", index1, mon_e.i1);
`ifdef CFAR_PEAK_THRESH_EN
          check("hit_count", hit0, mon_e.hits);
          check("tie1_hit_count", hit1, mon_e.hits);
`endif
          $display("[TB] cycle %0d result max=%0d idx=%0d idx_last=%0d", cyc, max_value0, index0, index1);
        end
      end
    end
  end

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_max_value", max_value0, 0);
    check("reset_index_out", index0, 0);
    check("reset_max_valid", max_valid0, 0);
    check("reset_frame_err", frame_err0, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Valid samples in IDLE without frame_start must be dropped.
    repeat (3) drive(5000, 1'b0, 1'b1);

    for (int i = 0; i < FL; i++) frame_buf[i] = i;
    drive_frame(FL, 1'b0, 1'b0);

    for (int i = 0; i < FL; i++) frame_buf[i] = 7;
    frame_buf[3] = 9;
    frame_buf[200] = 9;
    drive_frame(FL, 1'b0, 1'b0);

    fill_random();
    frame_buf[400] = (1 << DW) - 1;
    drive_frame(FL, 1'b1, 1'b0);

    fill_random();
    drive_frame(100, 1'b0, 1'b0);
    fill_random();
    drive_frame(FL, 1'b0, 1'b1);

    fill_random();
    freeze_at = 250;
    drive_frame(FL, 1'b0, 1'b0);
    fill_random();
    freeze_at = FL - 1;
    drive_frame(FL, 1'b0, 1'b0);
    freeze_at = -1;

    fill_random();
    drive_frame(300, 1'b0, 1'b0);
    drive(frame_buf[300], 1'b0, 1'b1);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    input_valid = 1'b0;
    @(negedge clk);
    check("midreset_max_value", max_value0, 0);
    check("midreset_index_out", index0, 0);

    for (int i = 0; i < FL; i++) begin
      if (i < 37) frame_buf[i] = 1001 + i * 7;
      else if (i < 42) frame_buf[i] = 1000;
      else frame_buf[i] = int'($urandom_range(999, 0));
    end
    drive_frame(FL, 1'b0, 1'b0);
    drive(0, 1'b0, 1'b0);

    for (int t = 0; t < 50 && sb.size() != 0; t++) @(posedge clk);
    check("scoreboard_drained", sb.size(), 0);
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("pulse_count", seen, pushed);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
